// File: rtl/draw_arbiter_pkg.sv
// Shared types and constants for the round-robin draw-engine arbiter.
// Used by draw_arbiter and rr_pick4.
package draw_arbiter_pkg;

  localparam int N_REQ         = 4;
  localparam int WAIT_BUSY_LIM = 4;
  localparam int DEF_CMD_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_FIN       = 3'd4
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/draw_arbiter_rr_pick4.sv
// Combinational round-robin pick among four requesters; the search starts
// one past the last served requester and wraps modulo 4.
module rr_pick4
  import draw_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_last,
  output logic [N_REQ-1:0] o_winner,
  output logic             o_valid
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = i_last + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter granting four requesters access to one draw engine.
// Define DRAW_ARB_TIMEOUT_EN to enable the WAIT_IDLE timeout and TMO_ERR flag.
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int CMD_W   = DEF_CMD_W,
  parameter int TMO_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*CMD_W-1:0] i_cmd,
  input  logic                   i_eng_idle,
  output logic                   o_eng_start,
  output logic [CMD_W-1:0]       o_eng_cmd,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy,
  output logic                   o_tmo_err
);

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  if (TMO_CYC < 1 || TMO_CYC > 256) begin : g_bad_tmo_cyc
    $error("draw_arbiter: TMO_CYC must be in 1..256");
  end

  state_t           r_state;
  state_t           w_next;
  logic [N_REQ-1:0] r_gnt;
  logic [CMD_W-1:0] r_cmd;
  logic [1:0]       r_last;
  logic [1:0]       r_wb_cnt;
  logic [N_REQ-1:0] w_winner;
  logic [1:0]       w_win_idx;
  logic             w_valid;
  logic             w_grant;
  logic             w_wb_expired;
  logic             w_tmo_hit;

  rr_pick4 u_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_win_idx    = onehot_to_idx(w_winner);
  assign w_grant      = w_valid && i_eng_idle;
  assign w_wb_expired = i_eng_idle && (r_wb_cnt == 2'(WAIT_BUSY_LIM - 1));

`ifdef DRAW_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  logic [7:0] r_tmo_cnt;
  logic       r_tmo_err;

  assign w_tmo_hit = (r_state == ST_WAIT_IDLE) && !i_eng_idle && (r_tmo_cnt == TMO_LAST);

  // Counter is parked at zero while in WAIT_BUSY so each WAIT_IDLE starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state == ST_WAIT_BUSY)      r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT_IDLE) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if (w_tmo_hit) r_tmo_err <= 1'b1;
    end
  end

  assign o_tmo_err = r_tmo_err;
`else
  assign w_tmo_hit = 1'b0;
  assign o_tmo_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_grant) w_next = ST_START;
      ST_START:     w_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!i_eng_idle)       w_next = ST_WAIT_IDLE;
        else if (w_wb_expired) w_next = ST_FIN;
      end
      ST_WAIT_IDLE: if (i_eng_idle || w_tmo_hit) w_next = ST_FIN;
      ST_FIN:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_eng_start = (r_state == ST_START);
    o_busy      = (r_state != ST_IDLE);
    o_done      = (r_state == ST_FIN) ? r_gnt : '0;
    o_gnt       = r_gnt;
    o_eng_cmd   = r_cmd;
  end

  // Grant, command and round-robin pointer; last served moves only on completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt    <= '0;
      r_cmd    <= '0;
      r_last   <= 2'd3;
      r_wb_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt <= w_winner;
            r_cmd <= i_cmd[w_win_idx*CMD_W +: CMD_W];
          end
        end
        ST_START:     r_wb_cnt <= '0;
        ST_WAIT_BUSY: if (i_eng_idle) r_wb_cnt <= r_wb_cnt + 2'd1;
        ST_FIN: begin
          r_last <= onehot_to_idx(r_gnt);
          r_gnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed scenarios plus randomized
// operations predicted by a transaction-level round-robin model.
module tb_draw_arbiter;

  localparam int CMD_W = 8;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [3:0]         i_req;
  logic [4*CMD_W-1:0] i_cmd;
  logic               i_eng_idle;
  logic               o_eng_start;
  logic [CMD_W-1:0]   o_eng_cmd;
  logic [3:0]         o_gnt;
  logic [3:0]         o_done;
  logic               o_busy;
  logic               o_tmo_err;

  int n_checks = 0;
  int n_fail   = 0;
  int last_srv = 3;
  int exp_idx;
  logic [3:0]       exp_gnt;
  logic [CMD_W-1:0] exp_cmd;

  draw_arbiter dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_cmd       (i_cmd),
    .i_eng_idle  (i_eng_idle),
    .o_eng_start (o_eng_start),
    .o_eng_cmd   (o_eng_cmd),
    .o_gnt       (o_gnt),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_tmo_err   (o_tmo_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  // Round-robin rule: first requester found scanning from last served + 1.
  function automatic int pick_idx(input logic [3:0] mask, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic predict();
    exp_idx = pick_idx(i_req, last_srv);
    exp_gnt = 4'(1 << exp_idx);
    exp_cmd = i_cmd[exp_idx*CMD_W +: CMD_W];
  endtask

  task automatic scramble(input int sc);
    if (sc == 0)      i_req = 4'($urandom);
    else if (sc == 2) i_req = 4'b0000;
    i_cmd = 32'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_gnt"}, o_gnt, 4'b0);
    check({tag, "_done"}, o_done, 4'b0);
    check({tag, "_start"}, o_eng_start, 1'b0);
  endtask

  task automatic check_hold();
    check("hold_busy", o_busy, 1'b1);
    check("hold_gnt", o_gnt, exp_gnt);
    check("hold_cmd", o_eng_cmd, exp_cmd);
    check("hold_start", o_eng_start, 1'b0);
    check("hold_done", o_done, 4'b0);
  endtask

  // Called at a negedge with the DUT in IDLE and a request applied.
  // mode 0: engine idles d cycles, busy len (>=2) cycles; mode 1: engine ignores start.
  task automatic run_op(input int mode, input int d, input int len, input int sc,
                        input logic [3:0] next_mask);
    int total;
    predict();
    step();
    check("start_pulse", o_eng_start, 1'b1);
    check("start_gnt", o_gnt, exp_gnt);
    check("start_cmd", o_eng_cmd, exp_cmd);
    check("start_busy", o_busy, 1'b1);
    scramble(sc);
    total = (mode == 1) ? 5 : d + len + 1;
    i_eng_idle = (mode == 1 || d != 0);
    for (int c = 1; c < total; c++) begin
      step();
      check_hold();
      scramble(sc);
      if (mode == 0) i_eng_idle = !(c >= d && c < d + len);
    end
    step();
    check("done_pulse", o_done, exp_gnt);
    check("done_gnt", o_gnt, exp_gnt);
    check("done_cmd", o_eng_cmd, exp_cmd);
    check("done_tmo", o_tmo_err, 1'b0);
    last_srv   = exp_idx;
    i_req      = next_mask;
    i_cmd      = 32'($urandom);
    i_eng_idle = 1'b1;
    step();
    check_idle("post");
  endtask

  initial begin
    int bad;
    logic [3:0] nm;
    i_rst = 1'b1; i_req = '0; i_cmd = '0; i_eng_idle = 1'b1;
    step(); step();
    check("rst_start", o_eng_start, 1'b0);
    check("rst_cmd", o_eng_cmd, '0);
    check("rst_gnt", o_gnt, 4'b0);
    check("rst_done", o_done, 4'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_tmo", o_tmo_err, 1'b0);
    i_rst = 1'b0;
    step();
    check_idle("idle0");

    // Contention with all four requests held: order 0,1,2,3,0.
    i_req = 4'b1111; i_cmd = 32'($urandom);
    for (int n = 0; n < 5; n++)
      run_op(0, $urandom_range(0, 3), $urandom_range(2, 6), 1, (n < 4) ? 4'b1111 : 4'b0000);

    // Single request, engine busy 5 cycles.
    i_req = 4'b0001; i_cmd = {24'($urandom), 8'h25};
    run_op(0, 1, 5, 1, 4'b0000);

    // A busy engine blocks any grant from IDLE.
    i_req = 4'b0100; i_eng_idle = 1'b0;
    step();
    check("blk_start", o_eng_start, 1'b0);
    check("blk_busy", o_busy, 1'b0);
    step();
    check("blk_gnt", o_gnt, 4'b0);
    i_eng_idle = 1'b1;
    run_op(1, 0, 0, 0, 4'b0000);

    // Randomized operations with random requests during the operation.
    i_req = 4'($urandom_range(1, 15));
    for (int n = 0; n < 40; n++) begin
      nm = (n < 39) ? 4'($urandom_range(1, 15)) : 4'b0000;
      run_op(($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 3),
             $urandom_range(2, 9), 0, nm);
    end

    // Requester withdraws during the operation.
    i_req = 4'b0001; i_cmd = 32'($urandom);
    run_op(0, 0, 6, 2, 4'b0000);

    // Reset while waiting for the engine to finish.
    i_req = 4'b0100;
    step();
    check("mid_start", o_eng_start, 1'b1);
    i_eng_idle = 1'b0;
    step(); step(); step();
    i_rst = 1'b1;
    step();
    check("mid_rst_start", o_eng_start, 1'b0);
    check("mid_rst_cmd", o_eng_cmd, '0);
    check("mid_rst_gnt", o_gnt, 4'b0);
    check("mid_rst_done", o_done, 4'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    i_rst = 1'b0; i_eng_idle = 1'b1; i_req = 4'b0000; last_srv = 3;
    step();
    check_idle("mid_after");
    i_req = 4'b0010; i_cmd = 32'($urandom);
    run_op(0, 2, 3, 0, 4'b0000);

    // Engine stuck drawing.
    i_req = 4'b1000; i_cmd = 32'($urandom);
    predict();
    step();
    check("stk_start", o_eng_start, 1'b1);
    i_eng_idle = 1'b0; i_req = 4'b0000;
    bad = 0;
`ifdef DRAW_ARB_TIMEOUT_EN
    for (int c = 1; c <= 256; c++) begin
      step();
      if (o_done !== 4'b0 || o_tmo_err !== 1'b0) bad++;
    end
    check("tmo_quiet", bad, 0);
    step();
    check("tmo_done", o_done, exp_gnt);
    check("tmo_err_set", o_tmo_err, 1'b1);
    last_srv = exp_idx;
    i_eng_idle = 1'b1;
    step(); step();
    check("tmo_sticky", o_tmo_err, 1'b1);
    check("tmo_idle", o_busy, 1'b0);
    i_rst = 1'b1;
    step();
    check("tmo_rst", o_tmo_err, 1'b0);
    i_rst = 1'b0; last_srv = 3;
    step();
`else
    for (int c = 1; c <= 300; c++) begin
      step();
      if (o_done !== 4'b0 || o_busy !== 1'b1) bad++;
    end
    check("stk_quiet", bad, 0);
    i_eng_idle = 1'b1;
    step();
    check("stk_done", o_done, exp_gnt);
    check("stk_tmo", o_tmo_err, 1'b0);
    last_srv = exp_idx;
    step();
    check_idle("stk_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter CMD_W, default 8, width of one draw command (peg index, disk size).
REQ-002 Parameter TMO_CYC, default 255, maximum cycles the engine may stay busy before a timeout.
REQ-003 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 REQ  in  4  per-requester draw request level; bit 0 is requester 0.
REQ-006 CMD  in  4*CMD_W  per-requester command; requester i uses bits [i*CMD_W +: CMD_W].
REQ-007 ENG_IDLE  in  1  draw-engine idle flag: 1 idle, 0 drawing.
REQ-008 ENG_START  out  1  one-cycle start pulse to the draw engine's data-done input.
REQ-009 ENG_CMD  out  CMD_W  command latched for the granted requester; stable from ENG_START until DONE.
REQ-010 GNT  out  4  one-hot grant; held for the whole operation.
REQ-011 DONE  out  4  one-hot, one-cycle completion pulse to the served requester.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 TMO_ERR  out  1  sticky timeout flag.

Function
REQ-014 FSM states: IDLE, START, WAIT_BUSY, WAIT_IDLE, FIN.
REQ-015 IDLE: if any REQ bit is high and ENG_IDLE=1, pick a winner, latch its CMD into ENG_CMD, set GNT, and go to START; otherwise stay.
REQ-016 Arbitration is round-robin: search starts at (last served + 1) mod 4; after reset, last served = 3, so requester 0 has top priority.
REQ-017 START lasts exactly one cycle with ENG_START=1, then goes to WAIT_BUSY; latency from REQ high in IDLE to ENG_START is 1 cycle.
REQ-018 WAIT_BUSY: go to WAIT_IDLE when ENG_IDLE=0; if ENG_IDLE stays 1 for 4 cycles, go to FIN (engine ignored the start; still counts as complete).
REQ-019 WAIT_IDLE: go to FIN when ENG_IDLE=1.
REQ-020 FIN lasts one cycle: DONE = GNT, update last served, clear GNT on exit, and return to IDLE.
REQ-021 The requester drops REQ in the cycle DONE is high; a REQ still high in the following IDLE cycle is treated as a new request.
REQ-022 If REQ drops mid-operation, the operation still completes and DONE still pulses.
REQ-023 REQ and CMD of non-granted requesters are ignored while BUSY=1.
REQ-024 At most one GNT bit and one DONE bit are ever high.

Reset
REQ-025 When RST=1 at a clock edge, the next state is IDLE and every output is 0, regardless of the current state.
REQ-026 On reset, last served = 3, the timeout counter = 0, and TMO_ERR is cleared.
REQ-027 A reset during an operation drops the operation without a DONE pulse.

Configuration
REQ-028 Macro DRAW_ARB_TIMEOUT_EN defined: an 8-bit counter runs in WAIT_IDLE.
REQ-029 With the macro defined, reaching TMO_CYC sets TMO_ERR and forces FIN, so DONE still pulses.
REQ-030 With the macro defined, the counter clears on every entry to WAIT_IDLE.
REQ-031 Macro not defined: no timeout counter; TMO_ERR is tied to 0 and WAIT_IDLE waits indefinitely.

Structure
REQ-032 A shared package holds: the FSM state encoding, N_REQ=4, the WAIT_BUSY limit of 4, and the default CMD_W.
REQ-033 The round-robin pick is one combinational sub-module, rr_pick4 (inputs: 4-bit request, 2-bit last served; outputs: one-hot winner, valid).
REQ-034 Target size is 120-400 lines of RTL including rr_pick4.

Verification
REQ-035 Single request: REQ=0001, CMD0=0x25, engine busy 5 cycles -> ENG_START 1 cycle after REQ, ENG_CMD=0x25, GNT=0001 held, DONE=0001 one cycle after ENG_IDLE returns to 1.
REQ-036 Contention: REQ=1111 held continuously -> grants in order 0,1,2,3,0, with no gap beyond FIN+IDLE between operations.
REQ-037 Unresponsive engine: ENG_IDLE held at 1 after ENG_START -> FIN after 4 WAIT_BUSY cycles, DONE pulsed, TMO_ERR=0.
REQ-038 Timeout (macro defined, TMO_CYC=255): ENG_IDLE stuck at 0 -> TMO_ERR=1 at cycle 255 of WAIT_IDLE, DONE pulsed; TMO_ERR stays 1 until RST.
REQ-039 Reset mid-operation: RST in WAIT_IDLE -> next cycle all outputs 0, no DONE; a later REQ=0010 is granted to requester 0 priority order (1 wins).
REQ-040 Request withdrawal: REQ0 dropped during WAIT_IDLE -> operation completes and DONE=0001 still pulses.
